alu_ctrl_seq: RTL and testbench
===============================

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width, legal values 4..64.
REQ-002 SHALL have parameter CTRL_W, default 4, ALUCtrl_o width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port valid_i, input, 1, instruction in the EX stage is valid.
REQ-006 SHALL have port funct_i, input, 6, R-type funct field.
REQ-007 SHALL have port ALUOp_i, input, 3, class code from main decoder.
REQ-008 SHALL have ports src1_i and src2_i, input, WIDTH each, multiply operands.
REQ-009 SHALL have port ALUCtrl_o, output, CTRL_W, ALU operation select.
REQ-010 SHALL have port stall_o, output, 1, hold the pipeline.
REQ-011 SHALL have port hi_o and lo_o, output, WIDTH each, registered product halves.
REQ-012 SHALL have port mul_done_o, output, 1, one-cycle product-valid pulse.
REQ-013 SHALL have port illegal_o, output, 1, unsupported opcode flag.

Function
REQ-014 SHALL decode ALUCtrl_o combinationally: ALUOp 0 (R-type) by funct: 32 add 0010, 34 sub 0110, 36 and 0001, 37 or 0000, 42 slt 0111, 24 mult 1110, 25 multu 1110, other 1111.
REQ-015 SHALL map ALUOp 1 addi->0010, 2 slti->0111, 3 beq->0110, 4 andi->0001, 5 ori->0000, 6 bne->0110, 7->1111.
REQ-016 SHALL drive illegal_o = valid_i and ALUCtrl_o==1111.
REQ-017 SHALL implement FSM IDLE, MUL, DONE; a mult/multu start is valid_i, ALUOp 0, funct 24/25, in IDLE or DONE.
REQ-018 On a start edge SHALL latch |src1_i|, |src2_i| (magnitudes only for funct 24), sign-of-result flag, clear step counter and 2*WIDTH accumulator, enter MUL.
REQ-019 SHALL in MUL perform one shift-add step per cycle, exactly WIDTH cycles, then register hi_o/lo_o and enter DONE.
REQ-020 SHALL negate the 2*WIDTH product before registering when the sign flag is set; -2^(WIDTH-1) operands SHALL be handled without overflow.
REQ-021 SHALL assert stall_o combinationally in the start cycle and every MUL cycle (WIDTH+1 cycles total); low in DONE and idle IDLE.
REQ-022 SHALL pulse mul_done_o high for the DONE cycle only, WIDTH+1 cycles after the start cycle; DONE returns to IDLE unless a new start occurs (back-to-back accepted).
REQ-023 SHALL ignore valid_i/funct_i for starting while in MUL; ALUCtrl_o still tracks inputs.
REQ-024 SHALL hold hi_o/lo_o stable except at the MUL->DONE edge and reset.

Reset
REQ-025 SHALL on rst_i high at an edge force IDLE, counter 0, accumulator 0, hi_o 0, lo_o 0, mul_done_o 0; stall_o then depends only on a new start.
REQ-026 SHALL abort an in-progress MUL on reset without updating hi_o/lo_o; reset wins over a simultaneous start.

Structure
REQ-027 SHALL place ALUCtrl codes, ALUOp codes, funct codes and FSM state encoding in shared package alu_ctrl_pkg.
REQ-028 SHALL instantiate combinational sub-module alu_ctrl_decode for REQ-014..016; sequencer and multiplier datapath SHALL live in alu_ctrl_seq.

Verification
REQ-029 SHALL cover decode sweep: every ALUOp, funct 32/34/36/37/42/0 -> codes per REQ-014/015, illegal_o=1 only for funct 0 and ALUOp 7 with valid_i=1.
REQ-030 SHALL cover multu WIDTH=32, 0xFFFFFFFF x 0xFFFFFFFF -> stall_o high 33 cycles, mul_done_o at cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 SHALL cover mult WIDTH=32, -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
REQ-032 SHALL cover back-to-back WIDTH=8: multu 15x15 then multu 2x3 issued in DONE -> hi/lo 0x00/0xE1 then 0x00/0x06, no IDLE gap.
REQ-033 SHALL cover reset at MUL step 10 -> IDLE next cycle, hi_o/lo_o 0, no mul_done_o pulse.
REQ-034 SHALL cover mult start during MUL -> ignored, original product unchanged, single mul_done_o.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and multiply sequencer:
// ALU select codes, ALUOp classes, R-type funct values and FSM states.
package alu_ctrl_pkg;

    localparam int unsigned ALU_CTRL_W = 4;
    localparam int unsigned ALUOP_W    = 3;
    localparam int unsigned FUNCT_W    = 6;

    localparam logic [ALU_CTRL_W-1:0] ALU_OR      = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND     = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD     = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB     = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT     = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL     = 4'b1110;
    localparam logic [ALU_CTRL_W-1:0] ALU_INVALID = 4'b1111;

    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'd0;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDI  = 3'd1;
    localparam logic [ALUOP_W-1:0] ALUOP_SLTI  = 3'd2;
    localparam logic [ALUOP_W-1:0] ALUOP_BEQ   = 3'd3;
    localparam logic [ALUOP_W-1:0] ALUOP_ANDI  = 3'd4;
    localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 3'd5;
    localparam logic [ALUOP_W-1:0] ALUOP_BNE   = 3'd6;

    localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'd24;
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'd25;
    localparam logic [FUNCT_W-1:0] FUNCT_ADD   = 6'd32;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB   = 6'd34;
    localparam logic [FUNCT_W-1:0] FUNCT_AND   = 6'd36;
    localparam logic [FUNCT_W-1:0] FUNCT_OR    = 6'd37;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT   = 6'd42;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Decode-side bundle: instruction class/funct in, ALU select and illegal flag out.
interface alu_ctrl_seq_if
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_W = 4
);
    logic                valid;
    logic [FUNCT_W-1:0]  funct;
    logic [ALUOP_W-1:0]  alu_op;
    logic [CTRL_W-1:0]   alu_ctrl;
    logic                illegal;

    modport master (output valid, funct, alu_op, input alu_ctrl, illegal);
    modport slave  (input valid, funct, alu_op, output alu_ctrl, illegal);
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode: ALUOp class plus R-type funct to ALU select,
// with an illegal flag for valid instructions that map to the invalid code.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_W = 4
) (
    alu_ctrl_seq_if.slave bus
);

    logic [ALU_CTRL_W-1:0] w_code;

    always_comb begin
        w_code = ALU_INVALID;
        case (bus.alu_op)
            ALUOP_RTYPE: begin
                case (bus.funct)
                    FUNCT_ADD:               w_code = ALU_ADD;
                    FUNCT_SUB:               w_code = ALU_SUB;
                    FUNCT_AND:               w_code = ALU_AND;
                    FUNCT_OR:                w_code = ALU_OR;
                    FUNCT_SLT:               w_code = ALU_SLT;
                    FUNCT_MULT, FUNCT_MULTU: w_code = ALU_MUL;
                    default:                 w_code = ALU_INVALID;
                endcase
            end
            ALUOP_ADDI:            w_code = ALU_ADD;
            ALUOP_SLTI:            w_code = ALU_SLT;
            ALUOP_BEQ, ALUOP_BNE:  w_code = ALU_SUB;
            ALUOP_ANDI:            w_code = ALU_AND;
            ALUOP_ORI:             w_code = ALU_OR;
            default:               w_code = ALU_INVALID;
        endcase
    end

    assign bus.alu_ctrl = CTRL_W'(w_code);
    assign bus.illegal  = bus.valid && (w_code == ALU_INVALID);

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control with a WIDTH-cycle shift-add multiplier for mult/multu; stalls the
// pipeline from the start cycle until the product is registered into hi/lo.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    input  logic [ALUOP_W-1:0]  ALUOp_i,
    input  logic [WIDTH-1:0]    src1_i,
    input  logic [WIDTH-1:0]    src2_i,
    output logic [CTRL_W-1:0]   ALUCtrl_o,
    output logic                stall_o,
    output logic [WIDTH-1:0]    hi_o,
    output logic [WIDTH-1:0]    lo_o,
    output logic                mul_done_o,
    output logic                illegal_o
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    alu_ctrl_seq_if #(.CTRL_W(CTRL_W)) u_dec_if ();

    assign u_dec_if.valid  = valid_i;
    assign u_dec_if.funct  = funct_i;
    assign u_dec_if.alu_op = ALUOp_i;

    alu_ctrl_decode #(.CTRL_W(CTRL_W)) u_decode (.bus(u_dec_if.slave));

    assign ALUCtrl_o = u_dec_if.alu_ctrl;
    assign illegal_o = u_dec_if.illegal;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [PW-1:0]      r_acc;
    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_mul_done;

    logic               w_is_mul;
    logic               w_start;
    logic               w_signed;
    logic               w_neg1;
    logic               w_neg2;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [PW-1:0]      w_acc_next;
    logic [PW-1:0]      w_prod;
    logic               w_last;

    // A new multiply is only accepted when the datapath is not mid-product.
    assign w_is_mul = valid_i && (ALUOp_i == ALUOP_RTYPE) &&
                      ((funct_i == FUNCT_MULT) || (funct_i == FUNCT_MULTU));
    assign w_start  = w_is_mul && (r_state != ST_MUL);

    // Unsigned magnitudes; -2^(WIDTH-1) becomes 2^(WIDTH-1), which still fits.
    assign w_signed = (funct_i == FUNCT_MULT);
    assign w_neg1   = w_signed && src1_i[WIDTH-1];
    assign w_neg2   = w_signed && src2_i[WIDTH-1];
    assign w_mag1   = w_neg1 ? ('0 - src1_i) : src1_i;
    assign w_mag2   = w_neg2 ? ('0 - src2_i) : src2_i;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod     = r_neg ? ('0 - w_acc_next) : w_acc_next;
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_neg      <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_mul_done <= 1'b0;
        end else begin
            r_mul_done <= 1'b0;
            case (r_state)
                ST_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_hi       <= w_prod[PW-1:WIDTH];
                        r_lo       <= w_prod[WIDTH-1:0];
                        r_mul_done <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                default: begin
                    if (w_start) begin
                        r_mcand  <= PW'(w_mag1);
                        r_mplier <= w_mag2;
                        r_neg    <= w_neg1 ^ w_neg2;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_state  <= ST_MUL;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign stall_o    = w_start || (r_state == ST_MUL);
    assign hi_o       = r_hi;
    assign lo_o       = r_lo;
    assign mul_done_o = r_mul_done;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: a 32-bit and an 8-bit instance share the decode inputs,
// checked against a plain-arithmetic product model and a decode lookup table.
module tb_alu_ctrl_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    alu_ctrl_seq_if #(.CTRL_W(4)) bus ();

    logic [31:0] s1_32, s2_32, hi32, lo32;
    logic        stall32, done32;
    logic [7:0]  s1_8, s2_8, hi8, lo8;
    logic        stall8, done8, illegal8;
    logic [3:0]  ctrl8;

    int errors = 0;
    int checks = 0;

    alu_ctrl_seq #(.WIDTH(32), .CTRL_W(4)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(bus.valid), .funct_i(bus.funct),
        .ALUOp_i(bus.alu_op), .src1_i(s1_32), .src2_i(s2_32),
        .ALUCtrl_o(bus.alu_ctrl), .stall_o(stall32), .hi_o(hi32), .lo_o(lo32),
        .mul_done_o(done32), .illegal_o(bus.illegal)
    );

    alu_ctrl_seq #(.WIDTH(8), .CTRL_W(4)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(bus.valid), .funct_i(bus.funct),
        .ALUOp_i(bus.alu_op), .src1_i(s1_8), .src2_i(s2_8),
        .ALUCtrl_o(ctrl8), .stall_o(stall8), .hi_o(hi8), .lo_o(lo8),
        .mul_done_o(done8), .illegal_o(illegal8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full-width signed/unsigned product of w-bit operands, truncated to 2w bits.
    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input bit sgn, input int w);
        logic signed [127:0] sa, sb, p;
        logic [127:0] mask;
        sa = $signed(128'(a));
        sb = $signed(128'(b));
        if (sgn && a[w-1]) sa = sa - (128'sd1 <<< w);
        if (sgn && b[w-1]) sb = sb - (128'sd1 <<< w);
        p = sa * sb;
        mask = (128'd1 << (2 * w)) - 128'd1;
        return p & mask;
    endfunction

    function automatic logic [3:0] ref_ctrl(input logic [2:0] op, input logic [5:0] f);
        logic [3:0] itype [8];
        itype = '{4'hF, 4'h2, 4'h7, 4'h6, 4'h1, 4'h0, 4'h6, 4'hF};
        if (op != 3'd0) return itype[op];
        case (f)
            6'd32:        return 4'h2;
            6'd34:        return 4'h6;
            6'd36:        return 4'h1;
            6'd37:        return 4'h0;
            6'd42:        return 4'h7;
            6'd24, 6'd25: return 4'hE;
            default:      return 4'hF;
        endcase
    endfunction

    // One multiply on both instances; inj>0 replays a mult start at that cycle.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                           input int inj, input string tag);
        logic [127:0] p32, p8;
        logic [31:0]  h0, l0;
        int st32, st8, dn32, dn8, at32, at8;
        bit stable;
        st32 = 0; st8 = 0; dn32 = 0; dn8 = 0; at32 = -1; at8 = -1; stable = 1'b1;
        p32 = ref_mul(64'(a), 64'(b), f == 6'd24, 32);
        p8  = ref_mul(64'(a[7:0]), 64'(b[7:0]), f == 6'd24, 8);
        @(negedge clk);
        h0 = hi32; l0 = lo32;
        bus.valid = 1'b1; bus.alu_op = 3'd0; bus.funct = f;
        s1_32 = a; s2_32 = b; s1_8 = a[7:0]; s2_8 = b[7:0];
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(negedge clk);
                bus.valid = (c == inj);
                if (c == inj) begin
                    bus.funct = 6'd24;
                    s1_32 = $urandom; s2_32 = $urandom;
                    s1_8 = 8'($urandom); s2_8 = 8'($urandom);
                end
            end
            #1;
            if (stall32) st32++;
            if (stall8)  st8++;
            if (done32) begin dn32++; if (at32 < 0) at32 = c; end
            if (done8)  begin dn8++;  if (at8 < 0)  at8 = c;  end
            if (c < 33 && (hi32 !== h0 || lo32 !== l0)) stable = 1'b0;
        end
        check({tag, "_stall32"}, 64'(st32), 64'd33);
        check({tag, "_doneat32"}, 64'(at32), 64'd33);
        check({tag, "_npulse32"}, 64'(dn32), 64'd1);
        check({tag, "_hi32"}, 64'(hi32), 64'(p32[63:32]));
        check({tag, "_lo32"}, 64'(lo32), 64'(p32[31:0]));
        check({tag, "_hold32"}, 64'(stable), 64'd1);
        check({tag, "_stall8"}, 64'(st8), 64'd9);
        check({tag, "_doneat8"}, 64'(at8), 64'd9);
        check({tag, "_npulse8"}, 64'(dn8), 64'd1);
        check({tag, "_hi8"}, 64'(hi8), 64'(p8[15:8]));
        check({tag, "_lo8"}, 64'(lo8), 64'(p8[7:0]));
    endtask

    initial begin
        logic [5:0] fl [8];
        logic [3:0] ec;
        int st, dn;
        fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd24, 6'd25};
        rst = 1'b1; bus.valid = 1'b0; bus.funct = 6'd0; bus.alu_op = 3'd0;
        s1_32 = '0; s2_32 = '0; s1_8 = '0; s2_8 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_hi32", 64'(hi32), 64'd0);
        check("rst_lo32", 64'(lo32), 64'd0);
        check("rst_done32", 64'(done32), 64'd0);
        check("rst_stall32", 64'(stall32), 64'd0);
        check("rst_hi8", 64'(hi8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        rst = 1'b0;

        // Decode sweep over every class, listed functs and both valid levels
        for (int op = 0; op < 8; op++) begin
            for (int fi = 0; fi < 8; fi++) begin
                for (int v = 0; v < 2; v++) begin
                    @(negedge clk);
                    bus.valid = (v == 1); bus.alu_op = 3'(op); bus.funct = fl[fi];
                    #1;
                    ec = ref_ctrl(3'(op), fl[fi]);
                    check("dec_ctrl32", 64'(bus.alu_ctrl), 64'(ec));
                    check("dec_ctrl8", 64'(ctrl8), 64'(ec));
                    check("dec_ill32", 64'(bus.illegal), 64'((v == 1) && ec == 4'hF));
                    check("dec_ill8", 64'(illegal8), 64'((v == 1) && ec == 4'hF));
                end
            end
        end
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            bus.valid = 1'b1; bus.alu_op = 3'($urandom_range(0, 7)); bus.funct = 6'($urandom);
            #1;
            ec = ref_ctrl(bus.alu_op, bus.funct);
            check("dec_rand_ctrl", 64'(bus.alu_ctrl), 64'(ec));
            check("dec_rand_ill", 64'(bus.illegal), 64'(ec == 4'hF));
        end

        // Clear any multiplies the sweep launched
        @(negedge clk);
        bus.valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Directed corner products
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd25, -1, "multu_max");
        check("multu_max_hi_k", 64'(hi32), 64'h0000_0000_FFFF_FFFE);
        check("multu_max_lo_k", 64'(lo32), 64'h0000_0000_0000_0001);
        run_mul(32'hFFFF_FFFD, 32'd7, 6'd24, -1, "mult_m3x7");
        check("mult_m3x7_hi_k", 64'(hi32), 64'h0000_0000_FFFF_FFFF);
        check("mult_m3x7_lo_k", 64'(lo32), 64'h0000_0000_FFFF_FFEB);
        run_mul(32'h8000_0000, 32'h8000_0000, 6'd24, -1, "mult_minsq");
        check("mult_minsq_hi_k", 64'(hi32), 64'h0000_0000_4000_0000);
        check("mult_minsq_lo_k", 64'(lo32), 64'd0);

        // Start attempt during MUL must be ignored
        run_mul(32'hFFFF_FFFD, 32'd7, 6'd24, 5, "mult_ign");
        check("mult_ign_lo_k", 64'(lo32), 64'h0000_0000_FFFF_FFEB);

        // Randomized products
        for (int i = 0; i < 10; i++) begin
            run_mul($urandom, $urandom, ($urandom_range(0, 1) == 1) ? 6'd24 : 6'd25, -1, "rand");
        end

        // Back-to-back on the 8-bit instance, second start issued in DONE
        @(negedge clk);
        bus.valid = 1'b1; bus.alu_op = 3'd0; bus.funct = 6'd25;
        s1_8 = 8'd15; s2_8 = 8'd15; s1_32 = '0; s2_32 = '0;
        st = 0; dn = 0;
        for (int c = 0; c < 26; c++) begin
            if (c > 0) begin
                @(negedge clk);
                bus.valid = (c == 9);
                if (c == 9) begin s1_8 = 8'd2; s2_8 = 8'd3; end
            end
            #1;
            if (stall8) st++;
            if (done8) dn++;
            if (c == 9) begin
                check("b2b_done1", 64'(done8), 64'd1);
                check("b2b_restall", 64'(stall8), 64'd1);
                check("b2b_hi1", 64'(hi8), 64'h00);
                check("b2b_lo1", 64'(lo8), 64'hE1);
            end
            if (c == 18) begin
                check("b2b_done2", 64'(done8), 64'd1);
                check("b2b_hi2", 64'(hi8), 64'h00);
                check("b2b_lo2", 64'(lo8), 64'h06);
            end
        end
        check("b2b_stall_total", 64'(st), 64'd18);
        check("b2b_pulses", 64'(dn), 64'd2);
        repeat (40) @(negedge clk);

        // Reset in the middle of a multiply
        @(negedge clk);
        bus.valid = 1'b1; bus.funct = 6'd25; s1_32 = 32'd7; s2_32 = 32'd9;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_stall", 64'(stall32), 64'd0);
        check("rstmid_hi", 64'(hi32), 64'd0);
        check("rstmid_lo", 64'(lo32), 64'd0);
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done32) dn++;
        end
        check("rstmid_nopulse", 64'(dn), 64'd0);
        check("rstmid_hold_lo", 64'(lo32), 64'd0);

        // Reset wins over a simultaneous start
        @(negedge clk);
        rst = 1'b1; bus.valid = 1'b1; bus.alu_op = 3'd0; bus.funct = 6'd24;
        s1_32 = 32'd5; s2_32 = 32'd6;
        @(negedge clk);
        rst = 1'b0; bus.valid = 1'b0;
        #1;
        check("rstwin_stall32", 64'(stall32), 64'd0);
        check("rstwin_stall8", 64'(stall8), 64'd0);
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done32 || done8) dn++;
        end
        check("rstwin_nopulse", 64'(dn), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
